// File: rtl/vga_color_arbiter.sv
// -----------------------------------------------------------------------------
// vga_color_arbiter
//
// Arbitrates colour-change requests from two requesters and applies the
// winning colour to the VGA datapath only at vertical blanking, so the visible
// picture never tears mid-frame.
//
// Flow: IDLE picks a winner round-robin and snapshots its colour into a
// pending register. WAIT_FRAME holds the grant until the next Frame_Start. A
// one-cycle APPLY then presents the new colour together with a single Ack pulse.
// If the granted requester withdraws its request while waiting, the grant is
// cancelled without an Ack.
//
// Optional feature (compile-time macro VGA_AUTO_CYCLE_EN):
//   While idle with no requests, every CYCLE_FRAMES frame starts the output
//   colour steps through five presets: red, green, blue, (244,201,188) and
//   (118,15,212), then wraps back to red. Without the macro the counter, the
//   preset index and the preset table are not built.
//
// Parameters:
//   CYCLE_FRAMES  idle frame starts between auto-cycle steps (macro builds only)
//
// Ports:
//   Clk_50MHz    in   1   sole clock, rising edge
//   Rst          in   1   synchronous active-high reset
//   Frame_Start  in   1   one-cycle pulse at start of vertical blanking
//   Req          in   2   level request per requester, held until Ack
//   Color0       in  24   requester 0 colour {R,G,B}
//   Color1       in  24   requester 1 colour {R,G,B}
//   Gnt          out  2   registered one-hot grant (or zero)
//   Ack          out  2   one-cycle pulse when the colour has been applied
//   Red          out  8   registered active red
//   Green        out  8   registered active green
//   Blue         out  8   registered active blue
//   Busy         out  1   registered, high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module vga_color_arbiter #(
   parameter int unsigned CYCLE_FRAMES = 60
) (
   input  logic        Clk_50MHz,
   input  logic        Rst,
   input  logic        Frame_Start,
   input  logic [1:0]  Req,
   input  logic [23:0] Color0,
   input  logic [23:0] Color1,
   output logic [1:0]  Gnt,
   output logic [1:0]  Ack,
   output logic [7:0]  Red,
   output logic [7:0]  Green,
   output logic [7:0]  Blue,
   output logic        Busy
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_FRAME = 2'd1,
      APPLY      = 2'd2
   } state_t;

   // Round-robin pick. Only meaningful when at least one request is high:
   // with both high the requester not served last wins, otherwise the only
   // active requester wins.
   function automatic logic rr_pick(input logic [1:0] req, input logic last_served);
      logic win;
      if (req == 2'b11) begin
         win = ~last_served;
      end else begin
         win = req[1];
      end
      return win;
   endfunction

   // Requester index to one-hot vector.
   function automatic logic [1:0] to_one_hot(input logic idx);
      logic [1:0] vec;
      if (idx) begin
         vec = 2'b10;
      end else begin
         vec = 2'b01;
      end
      return vec;
   endfunction

`ifdef VGA_AUTO_CYCLE_EN
   // Counter runs 0..CYCLE_FRAMES-1; the frame start that would take it to
   // CYCLE_FRAMES is the step frame, and the counter goes straight back to 0.
   localparam int unsigned CNT_W = (CYCLE_FRAMES > 1) ? $clog2(CYCLE_FRAMES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLE_FRAMES - 1);

   // Auto-cycle preset table.
   function automatic logic [23:0] preset_color(input logic [2:0] idx);
      logic [23:0] col;
      case (idx)
         3'd0:    col = {8'd255, 8'd0,   8'd0};
         3'd1:    col = {8'd0,   8'd255, 8'd0};
         3'd2:    col = {8'd0,   8'd0,   8'd255};
         3'd3:    col = {8'd244, 8'd201, 8'd188};
         3'd4:    col = {8'd118, 8'd15,  8'd212};
         default: col = {8'd255, 8'd0,   8'd0};
      endcase
      return col;
   endfunction

   logic [CNT_W-1:0] frame_cnt_r;
   logic [2:0]       preset_idx_r;
`endif

   state_t      state_r;
   logic [23:0] pending_r;
   logic        winner_r;       // index of the currently granted requester
   logic        last_served_r;  // index of the requester acknowledged last
   logic [1:0]  gnt_r;
   logic [1:0]  ack_r;
   logic [7:0]  red_r;
   logic [7:0]  green_r;
   logic [7:0]  blue_r;
   logic        busy_r;
   logic        pick_s;

   // Winner candidate for the current cycle's requests.
   always_comb begin
      pick_s = rr_pick(Req, last_served_r);
   end

   // Arbitration FSM with registered outputs and (optionally) auto-cycle.
   always_ff @(posedge Clk_50MHz) begin
      if (Rst) begin
         state_r       <= IDLE;
         pending_r     <= 24'h000000;
         winner_r      <= 1'b0;
         last_served_r <= 1'b1;
         gnt_r         <= 2'b00;
         ack_r         <= 2'b00;
         red_r         <= 8'd255;
         green_r       <= 8'd255;
         blue_r        <= 8'd255;
         busy_r        <= 1'b0;
`ifdef VGA_AUTO_CYCLE_EN
         frame_cnt_r   <= CNT_W'(0);
         preset_idx_r  <= 3'd0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               ack_r <= 2'b00;
               if (Req != 2'b00) begin
                  // Accept: colour is snapshotted now. A Frame_Start in this
                  // same cycle is deliberately ignored; the grant waits for
                  // the next one.
                  winner_r  <= pick_s;
                  pending_r <= pick_s ? Color1 : Color0;
                  gnt_r     <= to_one_hot(pick_s);
                  busy_r    <= 1'b1;
                  state_r   <= WAIT_FRAME;
`ifdef VGA_AUTO_CYCLE_EN
                  frame_cnt_r <= CNT_W'(0);
`endif
               end else begin
                  gnt_r   <= 2'b00;
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
`ifdef VGA_AUTO_CYCLE_EN
                  if (Frame_Start) begin
                     if (frame_cnt_r == CNT_LAST) begin
                        {red_r, green_r, blue_r} <= preset_color(preset_idx_r);
                        frame_cnt_r  <= CNT_W'(0);
                        preset_idx_r <= (preset_idx_r == 3'd4) ? 3'd0 : preset_idx_r + 3'd1;
                     end else begin
                        frame_cnt_r <= frame_cnt_r + CNT_W'(1);
                     end
                  end
`endif
               end
            end

            WAIT_FRAME: begin
               ack_r <= 2'b00;
               if (!Req[winner_r]) begin
                  // Withdrawal beats a simultaneous Frame_Start.
                  gnt_r   <= 2'b00;
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
               end else if (Frame_Start) begin
                  // Colour and Ack become visible together in the APPLY cycle.
                  {red_r, green_r, blue_r} <= pending_r;
                  ack_r         <= to_one_hot(winner_r);
                  gnt_r         <= 2'b00;
                  last_served_r <= winner_r;
                  busy_r        <= 1'b1;
                  state_r       <= APPLY;
               end else begin
                  state_r <= WAIT_FRAME;
               end
            end

            APPLY: begin
               // Requests are not sampled here: a requester still holding Req
               // in the next (IDLE) cycle is taken as a fresh request.
               ack_r   <= 2'b00;
               gnt_r   <= 2'b00;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end

            default: begin
               ack_r   <= 2'b00;
               gnt_r   <= 2'b00;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign Gnt   = gnt_r;
   assign Ack   = ack_r;
   assign Red   = red_r;
   assign Green = green_r;
   assign Blue  = blue_r;
   assign Busy  = busy_r;

endmodule

// File: tb/tb_vga_color_arbiter.sv
// -----------------------------------------------------------------------------
// Self-checking bench for vga_color_arbiter (default build).
// Stimulus issues request rounds and pushes each expected Ack/colour into a
// scoreboard queue; an independent negedge monitor pops and compares whenever
// the DUT raises Ack, and also watches grant/ack/colour invariants.
// -----------------------------------------------------------------------------
module tb_vga_color_arbiter;

   logic        Clk_50MHz = 1'b0;
   logic        Rst;
   logic        Frame_Start;
   logic [1:0]  Req;
   logic [23:0] Color0;
   logic [23:0] Color1;
   logic [1:0]  Gnt;
   logic [1:0]  Ack;
   logic [7:0]  Red;
   logic [7:0]  Green;
   logic [7:0]  Blue;
   logic        Busy;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state: who was served last and what colour is showing.
   logic        m_last;
   logic [23:0] m_rgb;
   logic [25:0] sb_q[$];   // {expected Ack one-hot, expected RGB}

   bit          mon_en = 1'b0;
   logic [1:0]  prev_ack = 2'b00;
   logic        prev_rst = 1'b1;
   logic [23:0] prev_rgb = 24'h000000;

   vga_color_arbiter #(.CYCLE_FRAMES(60)) dut (
      .Clk_50MHz   (Clk_50MHz),
      .Rst         (Rst),
      .Frame_Start (Frame_Start),
      .Req         (Req),
      .Color0      (Color0),
      .Color1      (Color1),
      .Gnt         (Gnt),
      .Ack         (Ack),
      .Red         (Red),
      .Green       (Green),
      .Blue        (Blue),
      .Busy        (Busy)
   );

   always #10 Clk_50MHz = ~Clk_50MHz;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge Clk_50MHz);
      #1;
   endtask

   // One request round starting with the DUT idle.
   // cancel_mode: 0 never, 1 random, 2 always (with Frame_Start in that cycle).
   task automatic do_round(input logic [1:0] pat, input int wait_cyc, input int cancel_mode,
                           input bit fs_at_accept, input logic [23:0] c0, input logic [23:0] c1);
      logic        w;
      logic [1:0]  g;
      logic [23:0] pend;
      int          d;
      bit          cancel;
      w    = (pat == 2'b11) ? ~m_last : pat[1];
      g    = w ? 2'b10 : 2'b01;
      pend = w ? c1 : c0;
      Req = pat; Color0 = c0; Color1 = c1; Frame_Start = fs_at_accept;
      step();
      Frame_Start = 1'b0;
      chk("gnt_on_accept", 32'(Gnt), 32'(g));
      chk("busy_on_accept", 32'(Busy), 32'd1);
      d = (wait_cyc < 0) ? int'($urandom_range(0, 5)) : wait_cyc;
      for (int i = 0; i < d; i++) begin
         Color0 = 24'($urandom); Color1 = 24'($urandom);
         step();
         chk("gnt_held", 32'(Gnt), 32'(g));
      end
      cancel = (cancel_mode == 2) || ((cancel_mode == 1) && ($urandom_range(0, 4) == 0));
      if (cancel) begin
         Req = 2'b00;
         Frame_Start = (cancel_mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
         step();
         Frame_Start = 1'b0;
         chk("gnt_after_cancel", 32'(Gnt), 32'd0);
         chk("busy_after_cancel", 32'(Busy), 32'd0);
         chk("rgb_after_cancel", 32'({Red, Green, Blue}), 32'(m_rgb));
      end else begin
         Frame_Start = 1'b1;
         sb_q.push_back({g, pend});
         step();
         Frame_Start = 1'b0;
         m_last = w;
         m_rgb  = pend;
         chk("gnt_in_ack_cycle", 32'(Gnt), 32'd0);
         chk("busy_in_ack_cycle", 32'(Busy), 32'd1);
         if ($urandom_range(0, 1) == 0) Req = 2'b00;
         step();
         Req = 2'b00;
         chk("busy_after_apply", 32'(Busy), 32'd0);
         chk("gnt_after_apply", 32'(Gnt), 32'd0);
      end
   endtask

   // Monitor: scoreboard pop on every Ack plus output invariants.
   always @(negedge Clk_50MHz) begin
      logic [25:0] exp;
      if (mon_en) begin
         n_cmp++;
         if (!(Gnt == 2'b00 || Gnt == 2'b01 || Gnt == 2'b10)) begin
            n_err++;
            $display("FAIL gnt_onehot: got %b, wanted one-hot or zero", Gnt);
         end
         if (Ack != 2'b00) begin
            chk("ack_single_cycle", 32'(prev_ack), 32'd0);
            n_cmp++;
            if (sb_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_ack: got Ack=%b, wanted no Ack (t=%0t)", Ack, $time);
            end else begin
               exp = sb_q.pop_front();
               if (Ack !== exp[25:24] || {Red, Green, Blue} !== exp[23:0]) begin
                  n_err++;
                  $display("FAIL ack_rgb: got Ack=%b rgb=%h, wanted Ack=%b rgb=%h",
                           Ack, {Red, Green, Blue}, exp[25:24], exp[23:0]);
               end
            end
         end else if (!prev_rst) begin
            chk("rgb_stable_without_ack", 32'({Red, Green, Blue}), 32'(prev_rgb));
         end
      end
      prev_ack = Ack;
      prev_rst = Rst;
      prev_rgb = {Red, Green, Blue};
   end

   initial begin
      #10ms;
      $display("FAIL watchdog: got timeout, wanted completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      Rst = 1'b1; Frame_Start = 1'b0; Req = 2'b00;
      Color0 = 24'h000000; Color1 = 24'h000000;
      m_last = 1'b1; m_rgb = 24'hFFFFFF;
      repeat (3) step();
      chk("reset_gnt", 32'(Gnt), 32'd0);
      chk("reset_ack", 32'(Ack), 32'd0);
      chk("reset_busy", 32'(Busy), 32'd0);
      chk("reset_rgb", 32'({Red, Green, Blue}), 32'hFFFFFF);
      Rst = 1'b0;
      mon_en = 1'b1;
      step();

      // Both requesting from reset: grants alternate 01, 10, 01.
      for (int i = 0; i < 3; i++)
         do_round(2'b11, 1, 0, 1'b0, 24'($urandom), 24'($urandom));
      chk("rr_last_after_three", 32'(m_last), 32'd0);

      // Single request, apply 10 cycles later with pure red.
      do_round(2'b01, 9, 0, 1'b0, 24'hFF0000, 24'($urandom));
      chk("rgb_red_applied", 32'({Red, Green, Blue}), 32'hFF0000);

      // Frame_Start in the acceptance cycle must not apply.
      do_round(2'b10, 2, 0, 1'b1, 24'($urandom), 24'($urandom));

      // Requester 1 withdraws exactly at Frame_Start: cancelled, no Ack.
      do_round(2'b10, 3, 2, 1'b0, 24'($urandom), 24'($urandom));

      // Idle frame starts leave the colour alone in this build.
      for (int i = 0; i < 4; i++) begin
         Frame_Start = 1'b1; step(); Frame_Start = 1'b0; step();
         chk("idle_fs_rgb", 32'({Red, Green, Blue}), 32'(m_rgb));
         chk("idle_fs_busy", 32'(Busy), 32'd0);
      end

      // Reset while a grant is pending: abandoned, colour back to white.
      Req = 2'b10; Color1 = 24'($urandom);
      step();
      chk("midrst_gnt_before", 32'(Gnt), 32'd2);
      Rst = 1'b1; Frame_Start = 1'b1;
      step();
      Rst = 1'b0; Frame_Start = 1'b0; Req = 2'b00;
      m_last = 1'b1; m_rgb = 24'hFFFFFF;
      chk("midrst_gnt", 32'(Gnt), 32'd0);
      chk("midrst_ack", 32'(Ack), 32'd0);
      chk("midrst_busy", 32'(Busy), 32'd0);
      chk("midrst_rgb", 32'({Red, Green, Blue}), 32'hFFFFFF);
      step();
      do_round(2'b11, 0, 0, 1'b0, 24'($urandom), 24'($urandom));

      // Randomized rounds.
      for (int i = 0; i < 150; i++) begin
         do_round(2'($urandom_range(1, 3)), -1, 1, ($urandom_range(0, 3) == 0),
                  24'($urandom), 24'($urandom));
         if ($urandom_range(0, 2) == 0) step();
      end

      repeat (3) step();
      chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/vga_color_arbiter.md
VGA_COLOR_ARBITER -- requirements
Module: vga_color_arbiter

Interface
REQ-001 SHALL provide parameter CYCLE_FRAMES, default 60: number of consecutive idle frame starts between auto-cycle colour steps (used only with VGA_AUTO_CYCLE_EN).
REQ-002 SHALL provide port Clk_50MHz  input  1: sole clock, all logic on rising edge.
REQ-003 SHALL provide port Rst  input  1: reset, synchronous, active-high.
REQ-004 SHALL provide port Frame_Start  input  1: one-cycle pulse from timing generator at start of vertical blanking.
REQ-005 SHALL provide port Req  input  2: per-requester colour-change request, level, held until Ack.
REQ-006 SHALL provide ports Color0, Color1  input  24 each: requested colour {R[23:16],G[15:8],B[7:0]} for requester 0 / 1.
REQ-007 SHALL provide port Gnt  output  2: one-hot grant, registered.
REQ-008 SHALL provide port Ack  output  2: one-cycle pulse, colour applied for that requester.
REQ-009 SHALL provide ports Red, Green, Blue  output  8 each: registered active colour to VGA datapath.
REQ-010 SHALL provide port Busy  output  1: high when state is not IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, WAIT_FRAME, APPLY.
REQ-012 IDLE: any Req bit high -> select winner round-robin (requester not served last wins ties), latch its Color into 24-bit pending register, set Gnt winner bit, go WAIT_FRAME; Gnt visible the cycle after Req sampled.
REQ-013 IDLE: Frame_Start in the same cycle a request is accepted SHALL NOT apply it; the request waits for the next Frame_Start.
REQ-014 WAIT_FRAME: granted Req bit low -> cancel: Gnt cleared, no Ack, last-served unchanged, return IDLE next cycle.
REQ-015 WAIT_FRAME: Frame_Start with granted Req high -> go APPLY; cancel has priority when both occur in the same cycle.
REQ-016 WAIT_FRAME: pending colour SHALL NOT re-sample Color inputs; changes after grant are ignored.
REQ-017 APPLY (one cycle): Red/Green/Blue load the pending register, Ack winner bit pulses for exactly one cycle, Gnt cleared, last-served updated to winner, return IDLE.
REQ-018 Red/Green/Blue SHALL change only in APPLY or on an auto-cycle step (REQ-023), so colour updates occur only at vertical blanking.
REQ-019 Req still high in the cycle after Ack SHALL be treated as a new request.
REQ-020 Gnt SHALL be one-hot or zero at all times; Ack SHALL be zero except in the APPLY output cycle.

Reset
REQ-021 Rst high SHALL force on next edge: state IDLE, Gnt=0, Ack=0, Busy=0, Red=Green=Blue=255, pending=0, last-served=1 (requester 0 wins first tie), auto-cycle counter=0, preset index=0; mid-operation reset abandons pending request without Ack.

Configuration
REQ-022 Macro VGA_AUTO_CYCLE_EN SHALL compile in the auto-cycle feature; without it, counter and preset index logic are absent and colour changes only via APPLY.
REQ-023 With VGA_AUTO_CYCLE_EN: in IDLE with Req=0, each Frame_Start increments a frame counter; when it reaches CYCLE_FRAMES, Red/Green/Blue load preset[index] in that cycle, counter returns to 0, index increments 0..4 and wraps 4->0.
REQ-024 Presets SHALL be: 0 (255,0,0), 1 (0,255,0), 2 (0,0,255), 3 (244,201,188), 4 (118,15,212).
REQ-025 Any request accepted SHALL clear the frame counter to 0; preset index SHALL be retained.

Verification
REQ-026 Req=01, Color0=0xFF0000, Frame_Start 10 cycles later -> Gnt=01 next cycle, RGB=(255,0,0) and Ack=01 one cycle after Frame_Start, Busy returns 0.
REQ-027 Req=11 from reset, then re-request both after each Ack -> grants alternate 01,10,01; each Ack single-cycle.
REQ-028 Req=10 with Frame_Start in the acceptance cycle -> no apply; applied only at following Frame_Start.
REQ-029 Grant requester 1, drop Req[1] in the same cycle as Frame_Start -> no Ack, RGB unchanged, IDLE next cycle.
REQ-030 VGA_AUTO_CYCLE_EN, CYCLE_FRAMES=2, Req=0, 12 Frame_Starts -> RGB steps red, green, blue, (244,201,188), (118,15,212), red on every 2nd Frame_Start; Rst mid-sequence -> RGB=255,255,255, next step red.
